// File: rtl/rv32_encoder.sv
// rtl/rv32_encoder.sv - RV32I field-to-instruction-word encoder with output FIFO
// Illegal field combinations store a zero word flagged by out_err, keeping order.
package rv32_encoder_pkg;
  typedef enum logic [5:0] {
    RV32_UNKNOWN = 6'd0,
    RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
    RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
    RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
    RV32_SB, RV32_SH, RV32_SW,
    RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
    RV32_SLLI, RV32_SRLI, RV32_SRAI,
    RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU,
    RV32_XOR, RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
    RV32_FENCE, RV32_FENCEI, RV32_ECALL, RV32_EBREAK,
    RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI
  } rv32_opcode_enum_t;
endpackage

module rv32_encoder
  import rv32_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  rv32_opcode_enum_t in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic [11:0]       in_csr,
  input  logic [3:0]        in_fence_pred,
  input  logic [3:0]        in_fence_succ,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_err,
  output logic [CNT_W-1:0]  enc_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CW_ONE  = 1;
  localparam logic [PW-1:0]    PW_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_FENCE, FMT_FIXED, FMT_BAD
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] fixed_word;
  logic [31:0] raw_word;
  logic        legal;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        imm_i_ok, imm_b_ok, imm_j_ok, imm_sh_ok, imm_u_ok;

  assign imm_i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm_b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign imm_j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign imm_sh_ok = ~(|in_imm[31:5]);
  assign imm_u_ok  = ~(|in_imm[11:0]);

  always_comb begin
    fmt        = FMT_BAD;
    op         = 7'b0000000;
    f3         = 3'b000;
    f7         = 7'b0000000;
    fixed_word = 32'h0;
    case (in_opcode)
      RV32_LUI:    begin fmt = FMT_U; op = 7'b0110111; end
      RV32_AUIPC:  begin fmt = FMT_U; op = 7'b0010111; end
      RV32_JAL:    begin fmt = FMT_J; op = 7'b1101111; end
      RV32_JALR:   begin fmt = FMT_I; op = 7'b1100111; end
      RV32_BEQ:    begin fmt = FMT_B; op = 7'b1100011; f3 = 3'b000; end
      RV32_BNE:    begin fmt = FMT_B; op = 7'b1100011; f3 = 3'b001; end
      RV32_BLT:    begin fmt = FMT_B; op = 7'b1100011; f3 = 3'b100; end
      RV32_BGE:    begin fmt = FMT_B; op = 7'b1100011; f3 = 3'b101; end
      RV32_BLTU:   begin fmt = FMT_B; op = 7'b1100011; f3 = 3'b110; end
      RV32_BGEU:   begin fmt = FMT_B; op = 7'b1100011; f3 = 3'b111; end
      RV32_LB:     begin fmt = FMT_I; op = 7'b0000011; f3 = 3'b000; end
      RV32_LH:     begin fmt = FMT_I; op = 7'b0000011; f3 = 3'b001; end
      RV32_LW:     begin fmt = FMT_I; op = 7'b0000011; f3 = 3'b010; end
      RV32_LBU:    begin fmt = FMT_I; op = 7'b0000011; f3 = 3'b100; end
      RV32_LHU:    begin fmt = FMT_I; op = 7'b0000011; f3 = 3'b101; end
      RV32_SB:     begin fmt = FMT_S; op = 7'b0100011; f3 = 3'b000; end
      RV32_SH:     begin fmt = FMT_S; op = 7'b0100011; f3 = 3'b001; end
      RV32_SW:     begin fmt = FMT_S; op = 7'b0100011; f3 = 3'b010; end
      RV32_ADDI:   begin fmt = FMT_I; op = 7'b0010011; f3 = 3'b000; end
      RV32_SLTI:   begin fmt = FMT_I; op = 7'b0010011; f3 = 3'b010; end
      RV32_SLTIU:  begin fmt = FMT_I; op = 7'b0010011; f3 = 3'b011; end
      RV32_XORI:   begin fmt = FMT_I; op = 7'b0010011; f3 = 3'b100; end
      RV32_ORI:    begin fmt = FMT_I; op = 7'b0010011; f3 = 3'b110; end
      RV32_ANDI:   begin fmt = FMT_I; op = 7'b0010011; f3 = 3'b111; end
      RV32_SLLI:   begin fmt = FMT_SH; op = 7'b0010011; f3 = 3'b001; end
      RV32_SRLI:   begin fmt = FMT_SH; op = 7'b0010011; f3 = 3'b101; end
      RV32_SRAI:   begin fmt = FMT_SH; op = 7'b0010011; f3 = 3'b101; f7 = 7'b0100000; end
      RV32_ADD:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b000; end
      RV32_SUB:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      RV32_SLL:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b001; end
      RV32_SLT:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b010; end
      RV32_SLTU:   begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b011; end
      RV32_XOR:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b100; end
      RV32_SRL:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b101; end
      RV32_SRA:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b101; f7 = 7'b0100000; end
      RV32_OR:     begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b110; end
      RV32_AND:    begin fmt = FMT_R; op = 7'b0110011; f3 = 3'b111; end
      RV32_FENCE:  begin fmt = FMT_FENCE; op = 7'b0001111; end
      RV32_FENCEI: begin fmt = FMT_FIXED; fixed_word = 32'h0000100F; end
      RV32_ECALL:  begin fmt = FMT_FIXED; fixed_word = 32'h00000073; end
      RV32_EBREAK: begin fmt = FMT_FIXED; fixed_word = 32'h00100073; end
      RV32_CSRRW:  begin fmt = FMT_CSR; op = 7'b1110011; f3 = 3'b001; end
      RV32_CSRRS:  begin fmt = FMT_CSR; op = 7'b1110011; f3 = 3'b010; end
      RV32_CSRRC:  begin fmt = FMT_CSR; op = 7'b1110011; f3 = 3'b011; end
      RV32_CSRRWI: begin fmt = FMT_CSR; op = 7'b1110011; f3 = 3'b101; end
      RV32_CSRRSI: begin fmt = FMT_CSR; op = 7'b1110011; f3 = 3'b110; end
      RV32_CSRRCI: begin fmt = FMT_CSR; op = 7'b1110011; f3 = 3'b111; end
      default:     fmt = FMT_BAD;
    endcase
  end

  // The immediate forms CSRRxI share the CSR layout: zimm rides in on in_rs1.
  always_comb begin
    raw_word = 32'h0;
    legal    = 1'b1;
    case (fmt)
      FMT_R:     raw_word = {f7, in_rs2, in_rs1, f3, in_rd, op};
      FMT_I:     begin raw_word = {in_imm[11:0], in_rs1, f3, in_rd, op}; legal = imm_i_ok; end
      FMT_SH:    begin raw_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, op}; legal = imm_sh_ok; end
      FMT_S:     begin raw_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], op}; legal = imm_i_ok; end
      FMT_B:     begin
        raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], op};
        legal    = imm_b_ok;
      end
      FMT_U:     begin raw_word = {in_imm[31:12], in_rd, op}; legal = imm_u_ok; end
      FMT_J:     begin
        raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
        legal    = imm_j_ok;
      end
      FMT_CSR:   raw_word = {in_csr, in_rs1, f3, in_rd, op};
      FMT_FENCE: raw_word = {4'b0000, in_fence_pred, in_fence_succ, 5'b00000, 3'b000, 5'b00000, op};
      FMT_FIXED: raw_word = fixed_word;
      default:   legal = 1'b0;
    endcase
    enc_word = legal ? raw_word : 32'h0;
    enc_err  = ~legal;
  end

  logic [32:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;
  logic             push, pop;

  assign in_ready  = (count_q < DEPTH_C) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_instr = out_valid ? mem_q[rptr_q][31:0] : 32'h0;
  assign out_err   = out_valid & mem_q[rptr_q][32];
  assign enc_count = enc_cnt_q;
  assign err_count = err_cnt_q;

  always_comb begin
    count_d = count_q;
    wptr_d  = push ? wptr_q + PW_ONE : wptr_q;
    rptr_d  = pop  ? rptr_q + PW_ONE : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW_ONE;
      2'b01:   count_d = count_q - CW_ONE;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push) mem_q[wptr_q] <= {enc_err, enc_word};
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push && !enc_err && (enc_cnt_q != '1)) enc_cnt_q <= enc_cnt_q + CNT_ONE;
      if (push &&  enc_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rv32_encoder.sv
// tb/tb_rv32_encoder.sv - scoreboard bench for rv32_encoder with directed vectors
module tb_rv32_encoder;
  import rv32_encoder_pkg::*;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  rv32_opcode_enum_t in_opcode;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm, out_instr;
  logic [11:0]       in_csr;
  logic [3:0]        in_fence_pred, in_fence_succ;
  logic [15:0]       enc_count, err_count;

  int checks = 0;
  int errs   = 0;
  int exp_enc = 0;
  int exp_err = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  rv32_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_csr(in_csr),
    .in_fence_pred(in_fence_pred), .in_fence_succ(in_fence_succ),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      logic [32:0] e;
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_word: got 0x%08h err=%0b expected none", out_instr, out_err);
      end else begin
        e = sb.pop_front();
        if ({out_err, out_instr} !== e) begin
          errs++;
          $display("FAIL word: got 0x%08h err=%0b expected 0x%08h err=%0b",
                   out_instr, out_err, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic send(input rv32_opcode_enum_t op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [11:0] csr,
                      input logic [3:0] pred, input logic [3:0] succ,
                      input logic [31:0] ew, input logic ee);
    int n = 0;
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_csr = csr; in_fence_pred = pred; in_fence_succ = succ; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errs++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back({ee, ew});
    if (ee) exp_err++; else exp_enc++;
    #1 in_valid = 1'b0;
  endtask

  task automatic addi(input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] ew, input logic ee);
    send(RV32_ADDI, rd, 5'd0, 5'd0, imm, 12'h0, 4'h0, 4'h0, ew, ee);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain_empty", sb.size(), 0);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = RV32_UNKNOWN; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    in_csr = '0; in_fence_pred = '0; in_fence_succ = '0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_instr", out_instr, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_enc_count", enc_count, 0);
    chk("reset_err_count", err_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_reset", in_ready, 1);

    out_ready = 1'b1;
    send(RV32_ADDI, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 12'h0, 4'h0, 4'h0, 32'hFFF10093, 1'b0);
    chk("addi_latency_valid", out_valid, 1);
    chk("addi_enc_count", enc_count, 1);
    send(RV32_SUB,    5'd3, 5'd1, 5'd2, 32'h0,        12'h0,   4'h0, 4'h0, 32'h402081B3, 1'b0);
    send(RV32_LUI,    5'd5, 5'd0, 5'd0, 32'h12345000, 12'h0,   4'h0, 4'h0, 32'h123452B7, 1'b0);
    send(RV32_JAL,    5'd1, 5'd0, 5'd0, 32'd8,        12'h0,   4'h0, 4'h0, 32'h008000EF, 1'b0);
    send(RV32_ECALL,  5'd0, 5'd0, 5'd0, 32'h0,        12'h0,   4'h0, 4'h0, 32'h00000073, 1'b0);
    send(RV32_EBREAK, 5'd0, 5'd0, 5'd0, 32'h0,        12'h0,   4'h0, 4'h0, 32'h00100073, 1'b0);
    send(RV32_BEQ,    5'd0, 5'd1, 5'd2, 32'd8,        12'h0,   4'h0, 4'h0, 32'h00208463, 1'b0);
    send(RV32_SW,     5'd0, 5'd2, 5'd5, 32'd12,       12'h0,   4'h0, 4'h0, 32'h00512623, 1'b0);
    send(RV32_SRAI,   5'd1, 5'd1, 5'd0, 32'd3,        12'h0,   4'h0, 4'h0, 32'h4030D093, 1'b0);
    send(RV32_CSRRW,  5'd1, 5'd2, 5'd0, 32'h0,        12'h300, 4'h0, 4'h0, 32'h300110F3, 1'b0);
    send(RV32_CSRRWI, 5'd2, 5'd5, 5'd0, 32'h0,        12'h305, 4'h0, 4'h0, 32'h3052D173, 1'b0);
    send(RV32_FENCE,  5'd0, 5'd0, 5'd0, 32'h0,        12'h0,   4'hF, 4'hF, 32'h0FF0000F, 1'b0);
    send(RV32_FENCEI, 5'd0, 5'd0, 5'd0, 32'h0,        12'h0,   4'h0, 4'h0, 32'h0000100F, 1'b0);
    send(RV32_BEQ,    5'd0, 5'd1, 5'd2, 32'd3,        12'h0,   4'h0, 4'h0, 32'h0, 1'b1);
    #1 chk("beq_odd_err_count", err_count, 1);
    addi(5'd1, 32'd2048, 32'h0, 1'b1);
    send(RV32_LUI,    5'd5, 5'd0, 5'd0, 32'h12345001, 12'h0,   4'h0, 4'h0, 32'h0, 1'b1);
    send(RV32_SRLI,   5'd1, 5'd1, 5'd0, 32'd32,       12'h0,   4'h0, 4'h0, 32'h0, 1'b1);
    send(RV32_UNKNOWN, 5'd1, 5'd1, 5'd1, 32'h0,       12'h0,   4'h0, 4'h0, 32'h0, 1'b1);
    send(rv32_opcode_enum_t'(6'd63), 5'd1, 5'd1, 5'd1, 32'h0, 12'h0, 4'h0, 4'h0, 32'h0, 1'b1);
    drain();
    chk("enc_count_after_vectors", enc_count, exp_enc);
    chk("err_count_after_vectors", err_count, exp_err);

    out_ready = 1'b0;
    addi(5'd1, 32'd1, 32'h00100093, 1'b0);
    addi(5'd1, 32'd2, 32'h00200093, 1'b0);
    chk("full_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    addi(5'd1, 32'd3, 32'h00300093, 1'b0);
    drain();

    out_ready = 1'b0;
    addi(5'd1, 32'd4, 32'h00400093, 1'b0);
    addi(5'd1, 32'd5, 32'h00500093, 1'b0);
    flush = 1'b1;
    in_opcode = RV32_ADDI; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd6; in_valid = 1'b1;
    #1 chk("flush_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_enc_count", enc_count, exp_enc);
    chk("flush_err_count", err_count, exp_err);
    out_ready = 1'b1;
    send(RV32_ADDI, 5'd2, 5'd2, 5'd0, 32'd7, 12'h0, 4'h0, 4'h0, 32'h00710113, 1'b0);
    drain();

    out_ready = 1'b0;
    addi(5'd1, 32'd8, 32'h00800093, 1'b0);
    addi(5'd1, 32'd9, 32'h00900093, 1'b0);
    chk("prereset_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_instr", out_instr, 0);
    chk("async_rst_out_err", out_err, 0);
    chk("async_rst_enc_count", enc_count, 0);
    chk("async_rst_err_count", err_count, 0);
    sb.delete();
    exp_enc = 0; exp_err = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_async_rst", in_ready, 1);
    out_ready = 1'b1;
    addi(5'd1, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    drain();
    chk("final_enc_count", enc_count, exp_enc);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule

// File: doc/rv32_encoder.md
Name: rv32_encoder

Overview:
- Inverse of the RV32I instruction decoder: turns decoded fields (opcode enum, register indices, immediate, CSR address, fence masks) into a 32-bit RV32I instruction word.
- Used by the self-check/testbench program generator and by the boot-time instruction-memory loader.
- Input side is valid/ready. Encoded words pass through a small output FIFO with valid/ready. Illegal field combinations are flagged per word and counted.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous FIFO clear
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- in_opcode  in  rv32_opcode_enum_t  instruction to encode
- in_rd, in_rs1, in_rs2  in  5 each  register indices; in_rs1 carries zimm for CSR*I
- in_imm  in  32  immediate, byte offset for B/J, full upper value for U, shamt in imm[4:0]
- in_csr  in  12  CSR address
- in_fence_pred, in_fence_succ  in  4 each  FENCE masks
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  encoded word
- out_err  out  1  head word is illegal
- enc_count  out  CNT_W  legal words accepted
- err_count  out  CNT_W  illegal words accepted

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Accept: in_valid && in_ready at a rising edge. The word is encoded combinationally and pushed in the same edge.
- in_ready = (fifo_count < FIFO_DEPTH) && !flush. It has no combinational path from out_ready, so pop and push never coincide on a full FIFO.
- Pop: out_valid && out_ready.
  - out_valid = (fifo_count != 0).
  - out_instr and out_err are the head entry, held stable while out_valid && !out_ready.
- Latency: a word accepted at edge N is visible at out_valid after edge N (one cycle) when the FIFO was empty. Order is strictly FIFO.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves fifo_count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- flush=1 at an edge:
  - fifo_count becomes 0 and out_valid=0 on the next cycle.
  - Accept is blocked that cycle.
  - Counters are unchanged.
- Encoding uses standard RV32I formats:
  - R: funct7 0100000 for SUB and SRA, otherwise 0000000.
  - SRLI/SLLI use funct7 0000000; SRAI uses 0100000.
  - FENCE: {0000, pred, succ, 00000, 000, 00000, 0001111}.
  - FENCEI: 0x0000100F.
  - ECALL: 0x00000073. EBREAK: 0x00100073.
  - CSRRx: {csr, rs1, funct3, rd, 1110011}; CSRRxI place zimm=in_rs1 in the rs1 field.
- Legality checks; a failure sets err:
  - I/S loads, stores and ALU-imm: in_imm[31:11] all equal (12-bit signed).
  - Shifts: in_imm[31:5]=0.
  - B: in_imm[31:12] all equal and in_imm[0]=0.
  - J: in_imm[31:20] all equal and in_imm[0]=0.
  - U: in_imm[11:0]=0.
  - RV32_UNKNOWN or any unsupported enum value: err.
- On err, the stored word is 0x00000000 with out_err=1. The entry still occupies a FIFO slot, so the consumer sees an ordered error marker.
- Counters:
  - enc_count increments per accepted legal word; err_count per accepted illegal word.
  - Both saturate at all-ones and are unaffected by pops.
- Reset asserted mid-transfer discards all FIFO contents immediately. Nothing partial is emitted after release.

Test Plan:
- ADDI rd=1, rs1=2, imm=-1 (0xFFFFFFFF), out_ready=1 -> out_instr=0xFFF10093, out_err=0, one cycle after accept; enc_count=1.
- SUB rd=3, rs1=1, rs2=2 -> 0x402081B3. LUI rd=5, imm=0x12345000 -> 0x123452B7. JAL rd=1, imm=8 -> 0x008000EF. ECALL -> 0x00000073. EBREAK -> 0x00100073.
- BEQ rs1=1, rs2=2, imm=3 (odd) -> out_instr=0, out_err=1, err_count=1. ADDI imm=2048 -> err. LUI imm=0x12345001 -> err.
- FIFO_DEPTH=2, out_ready=0, three back-to-back ADDIs with imm 1, 2, 3 -> in_ready drops after the second accept. Raise out_ready -> words emerge in order with imm 1, 2, 3, no loss or duplication.
- Two words buffered, flush pulse -> out_valid=0 the next cycle, in_ready=0 during flush, counters unchanged. A later ADDI encodes correctly.
- rst asserted asynchronously with the FIFO full -> out_valid, out_instr, out_err and counters go to 0 without waiting for a clock edge.
